// File: rtl/wb_alu.sv
// wb_alu: WIDTH-bit ALU slave on pipelined Wishbone with a 6502-layout flags register.
// Define ALU_MUL_EN to add the iterative shift-add multiplier at operation address 0x89.
module wb_alu #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [7:0]       i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [WIDTH-1:0] o_wb_data
);
  localparam logic [7:0] ADDR_A = 8'h00, ADDR_B = 8'h01, ADDR_FLAGS = 8'h02;
  localparam logic [7:0] ADDR_RES = 8'h03, ADDR_RESHI = 8'h04;
  localparam logic [7:0] OP_ADD = 8'h80, OP_ADC = 8'h81, OP_SUB = 8'h82, OP_SBC = 8'h83;
  localparam logic [7:0] OP_AND = 8'h84, OP_OR = 8'h85, OP_XOR = 8'h86;
  localparam logic [7:0] OP_ASL = 8'h87, OP_LSR = 8'h88;

  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             n_reg, v_reg, z_reg, c_reg;
  logic             ack_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] flags_rd, reshi_rd, rd_data, op_res, add_b;
  logic [WIDTH:0]   sum;
  logic             w_n, w_v, add_cin, op_upd, op_v, op_c, mul_req, accept;

  assign accept    = i_wb_stb && !o_wb_stall;
  assign o_wb_ack  = ack_reg;
  assign o_wb_data = data_reg;

  // N and V live at bits 7 and 6, which only exist on the bus when WIDTH >= 8.
  generate
    if (WIDTH >= 8) begin : g_wide_flags
      assign w_n = i_wb_data[7];
      assign w_v = i_wb_data[6];
      always_comb begin
        flags_rd    = '0;
        flags_rd[7] = n_reg;
        flags_rd[6] = v_reg;
        flags_rd[1] = z_reg;
        flags_rd[0] = c_reg;
      end
    end else begin : g_narrow_flags
      assign w_n = 1'b0;
      assign w_v = 1'b0;
      always_comb begin
        flags_rd    = '0;
        flags_rd[1] = z_reg;
        flags_rd[0] = c_reg;
      end
    end
  endgenerate

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] S_IDLE = 1'b0, S_MUL = 1'b1;
  localparam logic [7:0] OP_MUL = 8'h89;

  logic [0:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] mul_a_reg, hi_reg, lo_reg, reshi_reg, hi_next, lo_next;
  logic [WIDTH:0]   step_sum;
  logic             mul_last;

  // {hi,lo} starts as {0,B}; each step adds A into hi when lo[0] is set, then shifts right.
  always_comb begin
    step_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mul_a_reg} : '0);
    hi_next  = step_sum[WIDTH:1];
    lo_next  = {step_sum[0], lo_reg[WIDTH-1:1]};
  end

  assign mul_last   = (state_reg == S_MUL) && (cnt_reg == CW'(WIDTH - 1));
  assign o_wb_stall = (state_reg == S_MUL);
  assign reshi_rd   = reshi_reg;
`else
  assign o_wb_stall = 1'b0;
  assign reshi_rd   = '0;
`endif

  always_comb begin
    add_b   = (i_wb_addr == OP_SUB || i_wb_addr == OP_SBC) ? ~b_reg : b_reg;
    add_cin = (i_wb_addr == OP_SUB) ? 1'b1 : (i_wb_addr == OP_ADD) ? 1'b0 : c_reg;
    sum     = {1'b0, a_reg} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    op_upd  = 1'b0;
    mul_req = 1'b0;
    op_res  = '0;
    op_v    = v_reg;
    op_c    = c_reg;
    rd_data = '0;
    case (i_wb_addr)
      ADDR_A:     rd_data = a_reg;
      ADDR_B:     rd_data = b_reg;
      ADDR_FLAGS: rd_data = flags_rd;
      ADDR_RES:   rd_data = res_reg;
      ADDR_RESHI: rd_data = reshi_rd;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        op_upd = 1'b1;
        op_res = sum[WIDTH-1:0];
        op_c   = sum[WIDTH];
        op_v   = (a_reg[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: begin op_upd = 1'b1; op_res = a_reg & b_reg; end
      OP_OR:  begin op_upd = 1'b1; op_res = a_reg | b_reg; end
      OP_XOR: begin op_upd = 1'b1; op_res = a_reg ^ b_reg; end
      OP_ASL: begin op_upd = 1'b1; op_res = {a_reg[WIDTH-2:0], 1'b0}; op_c = a_reg[WIDTH-1]; end
      OP_LSR: begin op_upd = 1'b1; op_res = {1'b0, a_reg[WIDTH-1:1]}; op_c = a_reg[0]; end
`ifdef ALU_MUL_EN
      OP_MUL: mul_req = 1'b1;
`endif
      default: ;
    endcase
    if (op_upd) rd_data = op_res;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      n_reg    <= 1'b0;
      v_reg    <= 1'b0;
      z_reg    <= 1'b0;
      c_reg    <= 1'b0;
      ack_reg  <= 1'b0;
      data_reg <= '0;
`ifdef ALU_MUL_EN
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      mul_a_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      reshi_reg <= '0;
`endif
    end else begin
      ack_reg  <= 1'b0;
      data_reg <= '0;
      if (accept && i_wb_we) begin
        ack_reg <= 1'b1;
        case (i_wb_addr)
          ADDR_A: a_reg <= i_wb_data;
          ADDR_B: b_reg <= i_wb_data;
          ADDR_FLAGS: begin
            n_reg <= w_n;
            v_reg <= w_v;
            z_reg <= i_wb_data[1];
            c_reg <= i_wb_data[0];
          end
          default: ;
        endcase
      end else if (accept && !mul_req) begin
        ack_reg  <= 1'b1;
        data_reg <= rd_data;
        if (op_upd) begin
          res_reg <= op_res;
          n_reg   <= op_res[WIDTH-1];
          v_reg   <= op_v;
          z_reg   <= (op_res == '0);
          c_reg   <= op_c;
        end
      end
`ifdef ALU_MUL_EN
      if (accept && !i_wb_we && mul_req) begin
        state_reg <= S_MUL;
        cnt_reg   <= '0;
        mul_a_reg <= a_reg;
        hi_reg    <= '0;
        lo_reg    <= b_reg;
      end
      if (state_reg == S_MUL) begin
        hi_reg  <= hi_next;
        lo_reg  <= lo_next;
        cnt_reg <= cnt_reg + 1'b1;
        if (mul_last) begin
          state_reg <= S_IDLE;
          ack_reg   <= 1'b1;
          data_reg  <= lo_next;
          res_reg   <= lo_next;
          reshi_reg <= hi_next;
          n_reg     <= lo_next[WIDTH-1];
          z_reg     <= ({hi_next, lo_next} == '0);
          c_reg     <= (hi_next != '0);
        end
      end
`endif
    end
  end
endmodule
